operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch
// Description : Decode-stage operand fetch. Selects A/B operands from the
//               register file, EX-stage forwarding or the WB write. Inserts
//               load-use bubbles and holds the EX-stage register while
//               downstream stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int unsigned ZERO_REG = 31
) (
    input  logic        clk_i,
    input  logic        rst_i,

    // Upstream instruction handshake
    input  logic        if_valid_i,
    input  logic [31:0] if_instr_i,
    input  logic [31:0] if_pc_i,
    output logic        if_ready_o,

    // Register-file read ports (read data is combinational from the selects)
    output logic [4:0]  ra_sel_o,
    output logic [4:0]  rb_sel_o,
    input  logic [31:0] rf_a_dat_i,
    input  logic [31:0] rf_b_dat_i,

    // Forwarding from the instruction currently in EX
    input  logic        ex_fwd_valid_i,
    input  logic [4:0]  ex_fwd_rc_i,
    input  logic [31:0] ex_fwd_dat_i,
    input  logic        ex_fwd_load_i,

    // Register-file write in progress this cycle
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rc_i,
    input  logic [31:0] wb_dat_i,

    // Pipeline flush
    input  logic        flush_i,

    // Downstream handshake and payload
    output logic        ex_valid_o,
    input  logic        ex_ready_i,
    output logic [5:0]  ex_op_o,
    output logic [4:0]  ex_rc_o,
    output logic [31:0] ex_a_o,
    output logic [31:0] ex_b_o,
    output logic [31:0] ex_pc_o,

    // Load-use stall cycle counter
    output logic [15:0] stall_cnt_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [4:0]  c_ZERO_IDX  = 5'(ZERO_REG);
    localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

    // EX-stage slot states. BUBBLE is kept distinct from EMPTY so that an
    // inserted load-use bubble is visible in the state register.
    localparam logic [1:0]  c_EMPTY     = 2'd0;
    localparam logic [1:0]  c_FULL      = 2'd1;
    localparam logic [1:0]  c_BUBBLE    = 2'd2;

    // ------------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------------
    logic [5:0]  w_op;
    logic [4:0]  w_rc;
    logic [4:0]  w_ra;
    logic [4:0]  w_rb;
    logic [15:0] w_lit;
    logic        w_is_lit;

    assign w_op     = if_instr_i[31:26];
    assign w_rc     = if_instr_i[25:21];
    assign w_ra     = if_instr_i[20:16];
    assign w_rb     = if_instr_i[15:11];
    assign w_lit    = if_instr_i[15:0];
    // Literal-type ops reuse the rb field as part of the immediate
    assign w_is_lit = (w_op[5:4] == 2'b11);

    // Register-file addresses follow the raw instruction, valid or not
    assign ra_sel_o = w_ra;
    assign rb_sel_o = w_rb;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state_q;
    logic [5:0]  r_ex_op_q;
    logic [4:0]  r_ex_rc_q;
    logic [31:0] r_ex_a_q;
    logic [31:0] r_ex_b_q;
    logic [31:0] r_ex_pc_q;
    logic [15:0] r_stall_cnt_q;

    logic [1:0]  w_state_d;
    logic [5:0]  w_ex_op_d;
    logic [4:0]  w_ex_rc_d;
    logic [31:0] w_ex_a_d;
    logic [31:0] w_ex_b_d;
    logic [31:0] w_ex_pc_d;
    logic [15:0] w_stall_cnt_d;

    // ------------------------------------------------------------------------
    // Operand selection
    // Priority: hard-wired zero register, then EX forward (loads have no
    // result yet), then the WB write, then the register file. Checking the
    // zero register first also stops any forward targeting it.
    // ------------------------------------------------------------------------
    function automatic logic [31:0] f_select(
        input logic [4:0]  idx,
        input logic [31:0] rf_dat,
        input logic        fwd_valid,
        input logic [4:0]  fwd_rc,
        input logic [31:0] fwd_dat,
        input logic        fwd_load,
        input logic        wbv,
        input logic [4:0]  wbrc,
        input logic [31:0] wbdat
    );
        logic [31:0] res;
        if (idx == c_ZERO_IDX) begin
            res = 32'd0;
        end else if (fwd_valid && (fwd_rc == idx) && !fwd_load) begin
            res = fwd_dat;
        end else if (wbv && (wbrc == idx)) begin
            res = wbdat;
        end else begin
            res = rf_dat;
        end
        return res;
    endfunction

    logic [31:0] w_a_sel;
    logic [31:0] w_b_reg_sel;
    logic [31:0] w_b_sel;

    // Pick the A and B operand sources for the incoming instruction
    always_comb begin
        w_a_sel     = f_select(w_ra, rf_a_dat_i,
                               ex_fwd_valid_i, ex_fwd_rc_i, ex_fwd_dat_i, ex_fwd_load_i,
                               wb_valid_i, wb_rc_i, wb_dat_i);
        w_b_reg_sel = f_select(w_rb, rf_b_dat_i,
                               ex_fwd_valid_i, ex_fwd_rc_i, ex_fwd_dat_i, ex_fwd_load_i,
                               wb_valid_i, wb_rc_i, wb_dat_i);
        if (w_is_lit) begin
            w_b_sel = {{16{w_lit[15]}}, w_lit};
        end else begin
            w_b_sel = w_b_reg_sel;
        end
    end

    // ------------------------------------------------------------------------
    // Load-use hazard and handshake
    // ------------------------------------------------------------------------
    logic w_ra_hit;
    logic w_rb_hit;
    logic w_hazard;
    logic w_slot_free;
    logic w_ex_valid;

    assign w_ex_valid  = (r_state_q == c_FULL);
    assign w_slot_free = ~w_ex_valid | ex_ready_i;

    // A load in EX blocks any instruction that reads its destination; the
    // rb field is not a source for literal-type instructions.
    always_comb begin
        w_ra_hit = (ex_fwd_rc_i == w_ra);
        w_rb_hit = (ex_fwd_rc_i == w_rb) && !w_is_lit;
        w_hazard = if_valid_i && ex_fwd_valid_i && ex_fwd_load_i &&
                   (ex_fwd_rc_i != c_ZERO_IDX) && (w_ra_hit || w_rb_hit);
    end

    assign if_ready_o = w_slot_free & ~w_hazard & ~flush_i & ~rst_i;

    // ------------------------------------------------------------------------
    // Next-state logic for the EX slot, payload registers and stall counter
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d     = r_state_q;
        w_ex_op_d     = r_ex_op_q;
        w_ex_rc_d     = r_ex_rc_q;
        w_ex_a_d      = r_ex_a_q;
        w_ex_b_d      = r_ex_b_q;
        w_ex_pc_d     = r_ex_pc_q;
        w_stall_cnt_d = r_stall_cnt_q;

        if (flush_i) begin
            // Flush drops both the held and the incoming instruction
            w_state_d = c_EMPTY;
        end else if (w_slot_free) begin
            if (w_hazard) begin
                w_state_d = c_BUBBLE;
                if (r_stall_cnt_q != c_STALL_MAX) begin
                    w_stall_cnt_d = r_stall_cnt_q + 16'd1;
                end
            end else if (if_valid_i) begin
                w_state_d = c_FULL;
                w_ex_op_d = w_op;
                w_ex_rc_d = w_rc;
                w_ex_a_d  = w_a_sel;
                w_ex_b_d  = w_b_sel;
                w_ex_pc_d = if_pc_i;
            end else begin
                w_state_d = c_EMPTY;
            end
        end
        // FULL with downstream stalled: everything holds
    end

    // State and payload registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q     <= c_EMPTY;
            r_ex_op_q     <= 6'd0;
            r_ex_rc_q     <= 5'd0;
            r_ex_a_q      <= 32'd0;
            r_ex_b_q      <= 32'd0;
            r_ex_pc_q     <= 32'd0;
            r_stall_cnt_q <= 16'd0;
        end else begin
            r_state_q     <= w_state_d;
            r_ex_op_q     <= w_ex_op_d;
            r_ex_rc_q     <= w_ex_rc_d;
            r_ex_a_q      <= w_ex_a_d;
            r_ex_b_q      <= w_ex_b_d;
            r_ex_pc_q     <= w_ex_pc_d;
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ex_valid_o  = w_ex_valid;
    assign ex_op_o     = r_ex_op_q;
    assign ex_rc_o     = r_ex_rc_q;
    assign ex_a_o      = r_ex_a_q;
    assign ex_b_o      = r_ex_b_q;
    assign ex_pc_o     = r_ex_pc_q;
    assign stall_cnt_o = r_stall_cnt_q;

endmodule
`default_nettype wire
